// File: rtl/fnd_scan_controller.sv
// Scan controller for a 4-digit multiplexed 7-segment display: slot timing, anti-ghost
// blanking, per-frame digit snapshot and leading-zero suppression; all outputs registered.
module fnd_scan_controller #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_digits,
    input  logic        i_lz_en,
    input  logic        i_display_on,
    output logic [1:0]  o_digit_position,
    output logic        o_En,
    output logic [3:0]  o_digit_value,
    output logic        o_frame_tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t        state, state_next;
    logic [CW-1:0] count, count_next;
    logic [15:0]   snapshot, snapshot_next;
    logic [1:0]    position_next;
    logic [3:0]    value_next;
    logic          en_next;
    logic          tick_next;
    logic          wrap;

    // Digit k>0 is dark when leading-zero suppression is on and digits 3..k are all zero.
    function automatic logic suppressed(input logic [1:0] pos, input logic [15:0] snap,
                                        input logic lz);
        logic zero_above;
        zero_above = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            if (k >= int'(pos)) zero_above = zero_above & (snap[4*k +: 4] == 4'h0);
        end
        return lz && (pos != 2'd0) && zero_above;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_next    = state;
        position_next = o_digit_position;
        snapshot_next = snapshot;
        value_next    = o_digit_value;
        tick_next     = 1'b0;
        wrap          = (count == LAST_COUNT);
        count_next    = wrap ? '0 : count + 1'b1;

        case (state)
            BLANK: if (count == BLANK_LAST) state_next = SHOW;
            SHOW:  if (wrap)                state_next = BLANK;
            default:                        state_next = BLANK;
        endcase

        // Position, value and snapshot move only on the edge that enters BLANK.
        if (wrap) begin
            position_next = o_digit_position + 2'd1;
            if (o_digit_position == 2'd3) begin
                snapshot_next = i_digits;
                tick_next     = 1'b1;
            end
            value_next = snapshot_next[{position_next, 2'b00} +: 4];
        end

        en_next = 1'b1;
        if (state_next == SHOW)
            en_next = ~i_display_on | suppressed(position_next, snapshot_next, i_lz_en);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state            <= BLANK;
            count            <= '0;
            snapshot         <= 16'h0000;
            o_digit_position <= 2'd0;
            o_digit_value    <= 4'h0;
            o_En             <= 1'b1;
            o_frame_tick     <= 1'b0;
        end else begin
            state            <= state_next;
            count            <= count_next;
            snapshot         <= snapshot_next;
            o_digit_position <= position_next;
            o_digit_value    <= value_next;
            o_En             <= en_next;
            o_frame_tick     <= tick_next;
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller: a time-based reference model predicts every
// cycle's outputs for two parameterisations; a negedge monitor compares them.
module tb_fnd_scan_controller;

    localparam int CD   = 8;
    localparam int BC_A = 2;
    localparam int BC_B = 7;

    typedef struct packed {
        logic [1:0] pos;
        logic       en;
        logic [3:0] val;
        logic       tick;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = 16'h1234;
    logic        lz_en = 1'b0;
    logic        disp_on = 1'b1;

    logic [1:0] pos_a, pos_b;
    logic       en_a, en_b, tick_a, tick_b;
    logic [3:0] val_a, val_b;

    int checks = 0;
    int failures = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    fnd_scan_controller #(.CLK_DIV(CD), .BLANK_CYCLES(BC_A)) dut (
        .i_clk(clk), .i_reset(rst), .i_digits(digits), .i_lz_en(lz_en),
        .i_display_on(disp_on), .o_digit_position(pos_a), .o_En(en_a),
        .o_digit_value(val_a), .o_frame_tick(tick_a)
    );

    fnd_scan_controller #(.CLK_DIV(CD), .BLANK_CYCLES(BC_B)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_digits(digits), .i_lz_en(lz_en),
        .i_display_on(disp_on), .o_digit_position(pos_b), .o_En(en_b),
        .o_digit_value(val_b), .o_frame_tick(tick_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: everything follows from the number of edges since reset release.
    int          t_since = 0;
    logic [15:0] snap = 16'h0000;

    function automatic exp_t predict(input int t, input int bc, input logic [15:0] s,
                                     input logic disp, input logic lz);
        exp_t e;
        int   cnt, slot, p;
        bit   lead;
        cnt  = t % CD;
        slot = t / CD;
        p    = slot % 4;
        lead = lz && (p != 0);
        for (int k = p; k <= 3; k++) if (s[4*k +: 4] != 4'h0) lead = 1'b0;
        e.pos  = 2'(p);
        e.val  = s[4*p +: 4];
        e.tick = (cnt == 0) && (p == 0) && (slot > 0);
        e.en   = (cnt < bc) ? 1'b1 : (!disp || lead);
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            t_since = 0;
            snap    = 16'h0000;
        end else begin
            t_since++;
            if ((t_since % CD == 0) && ((t_since / CD) % 4 == 0)) snap = digits;
        end
        q_a.push_back(predict(t_since, BC_A, snap, disp_on, lz_en));
        q_b.push_back(predict(t_since, BC_B, snap, disp_on, lz_en));
    end

    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("a_position", 16'(pos_a), 16'(e.pos));
            check("a_en",       16'(en_a),  16'(e.en));
            check("a_value",    16'(val_a), 16'(e.val));
            check("a_tick",     16'(tick_a), 16'(e.tick));
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("b_position", 16'(pos_b), 16'(e.pos));
            check("b_en",       16'(en_b),  16'(e.en));
            check("b_value",    16'(val_b), 16'(e.val));
            check("b_tick",     16'(tick_b), 16'(e.tick));
        end
    end

    // Bounded wait for dut to reach a given position with its digit lit.
    task automatic wait_lit(input logic [1:0] p, input string name);
        int i;
        for (i = 0; i < 200 && !(pos_a == p && en_a == 1'b0); i++) @(negedge clk);
        check(name, 16'(i < 200), 16'd1);
    endtask

    initial begin
        // Reset and plain scan across the zero first frame and a 1234 frame.
        repeat (3) @(negedge clk);
        check("reset_en",  16'(en_a), 16'd1);
        check("reset_pos", 16'(pos_a), 16'd0);
        rst = 1'b0;
        repeat (4 * CD * 2) @(negedge clk);

        // Snapshot tear: change the input during the position-2 slot.
        wait_lit(2'd2, "wait_pos2");
        digits = 16'h5678;
        repeat (4 * CD * 2) @(negedge clk);

        // Leading-zero suppression.
        digits = 16'h0070;
        lz_en  = 1'b1;
        repeat (4 * CD * 2) @(negedge clk);
        digits = 16'h0000;
        repeat (4 * CD * 2) @(negedge clk);

        // Display off mid-SHOW, then back on mid-SHOW.
        lz_en  = 1'b0;
        digits = 16'h9A4F;
        repeat (4 * CD) @(negedge clk);
        wait_lit(2'd1, "wait_pos1");
        @(negedge clk);
        disp_on = 1'b0;
        repeat (CD * 5 + 3) @(negedge clk);
        disp_on = 1'b1;
        repeat (4 * CD) @(negedge clk);

        // Asynchronous reset during a lit position-3 slot.
        wait_lit(2'd3, "wait_pos3");
        #1 rst = 1'b1;
        #1;
        check("async_en",    16'(en_a),  16'd1);
        check("async_pos",   16'(pos_a), 16'd0);
        check("async_b_pos", 16'(pos_b), 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4 * CD * 2) @(negedge clk);

        // Randomised traffic, biased towards zero nibbles so suppression triggers often.
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k < 4; k++)
                    digits[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            end
            if ($urandom_range(0, 29) == 0) lz_en = ~lz_en;
            if ($urandom_range(0, 23) == 0) disp_on = ~disp_on;
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
